// File: rtl/strtol_pkg.sv
// Shared types and constants for the string-to-integer converter and its digit decoder.
package strtol_pkg;

  typedef enum logic [2:0] {
    INI  = 3'd0,
    LEAD = 3'd1,
    MEM  = 3'd2,
    ACC  = 3'd3,
    FIN  = 3'd4
  } strtol_sts;

  // Digit value reported for bytes that are not alphanumeric
  localparam logic [5:0] NA = 6'd63;

  localparam logic [7:0] SPC   = 8'h20;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] NUL   = 8'h00;

endpackage

// File: rtl/strtol_dig.sv
// ASCII digit decoder: maps a byte to its value in bases up to 36 and flags
// whether it is a usable digit for the given radix.
//   ch    : ASCII byte
//   base  : radix
//   dig_c : digit value 0..35, or NA
//   vld_c : byte is non-NUL and its value is below base
module strtol_dig
  import strtol_pkg::*;
(
  input  logic [7:0] ch,
  input  logic [5:0] base,
  output logic [5:0] dig_c,
  output logic       vld_c
);

  always_comb begin
    dig_c = NA;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      dig_c = 6'(ch - 8'h30);
    end else if (ch >= 8'h61 && ch <= 8'h7A) begin
      dig_c = 6'(ch - 8'h61 + 8'd10);
    end else if (ch >= 8'h41 && ch <= 8'h5A) begin
      dig_c = 6'(ch - 8'h41 + 8'd10);
    end
    vld_c = (ch != NUL) && (dig_c < base);
  end

endmodule

// File: rtl/strtol.sv
// String-to-integer converter for the number parser. Fetches one byte per
// advance from memory (one wait cycle per fetch), skips leading spaces, takes
// one optional sign, accumulates digits in a runtime radix and saturates.
//   clk, rst : clock, asynchronous active-low reset
//   en       : start request (honoured only when idle)
//   base     : radix, latched at start
//   ch       : current memory byte
//   st       : debug view of the state register
//   bsy      : conversion in progress
//   done     : one-cycle result strobe
//   ao       : combinational advance-address request
//   vo       : signed saturated result
//   ovf      : magnitude saturated
//   err      : no digits or invalid radix
//   nd       : digits consumed (saturating)
module strtol
  import strtol_pkg::*;
#(
  parameter int unsigned DSZ = 32,
  parameter int unsigned NSZ = 6
)
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [5:0]     base,
  input  logic [7:0]     ch,
  output logic [2:0]     st,
  output logic           bsy,
  output logic           done,
  output logic           ao,
  output logic [DSZ-1:0] vo,
  output logic           ovf,
  output logic           err,
  output logic [NSZ-1:0] nd
);

  // Accumulator headroom: mag * 36 + 35 fits in DSZ+6 bits
  localparam int unsigned AW = DSZ + 6;

  strtol_sts      state, state_nx;
  logic           ret, ret_nx;      // MEM return target: 1 = ACC, 0 = LEAD
  logic [5:0]     b;
  logic [DSZ-1:0] mag;
  logic           neg;
  logic [5:0]     dig;
  logic           dv;
  logic           base_ok;
  logic           is_sign;
  logic [AW-1:0]  prod;
  logic [AW-1:0]  lim;

  strtol_dig u_dig (
    .ch    (ch),
    .base  (b),
    .dig_c (dig),
    .vld_c (dv)
  );

  assign base_ok = (b >= 6'd2) && (b <= 6'd36);
  assign is_sign = (ch == MINUS) || (ch == PLUS);
  assign prod    = AW'(mag) * AW'(b) + AW'(dig);
  // Negative results may reach one step further than positive ones
  assign lim     = neg ? (AW'(1) << (DSZ - 1)) : ((AW'(1) << (DSZ - 1)) - AW'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INI;
      ret   <= 1'b0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    case (state)
      INI:  if (en) state_nx = LEAD;
      LEAD: begin
        if (!base_ok) begin
          state_nx = FIN;
        end else if (ch == SPC) begin
          state_nx = MEM;
          ret_nx   = 1'b0;
        end else if (is_sign) begin
          state_nx = MEM;
          ret_nx   = 1'b1;
        end else begin
          state_nx = ACC;
        end
      end
      MEM:  state_nx = ret ? ACC : LEAD;
      ACC: begin
        if (dv) begin
          state_nx = MEM;
          ret_nx   = 1'b1;
        end else begin
          state_nx = FIN;
        end
      end
      FIN:     state_nx = INI;
      default: state_nx = INI;
    endcase
  end

  // Fetch request and status decode
  always_comb begin
    ao = 1'b0;
    case (state)
      LEAD:    ao = base_ok && ((ch == SPC) || is_sign);
      ACC:     ao = dv;
      default: ao = 1'b0;
    endcase
  end

  assign st   = 3'(state);
  assign bsy  = (state == LEAD) || (state == MEM) || (state == ACC);
  assign done = (state == FIN);

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b   <= '0;
      mag <= '0;
      neg <= 1'b0;
      vo  <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
      nd  <= '0;
    end else begin
      case (state)
        INI: begin
          if (en) begin
            b   <= base;
            mag <= '0;
            neg <= 1'b0;
            ovf <= 1'b0;
            err <= 1'b0;
            nd  <= '0;
          end
        end
        LEAD: begin
          if (!base_ok) begin
            err <= 1'b1;
            vo  <= '0;
          end else if (ch == MINUS) begin
            neg <= 1'b1;
          end
        end
        ACC: begin
          if (dv) begin
            if (nd != '1) nd <= nd + NSZ'(1);
            // Once saturated the magnitude is frozen; digits are still counted
            if (!ovf) begin
              if (prod > lim) begin
                ovf <= 1'b1;
                mag <= lim[DSZ-1:0];
              end else begin
                mag <= prod[DSZ-1:0];
              end
            end
          end else begin
            err <= (nd == NSZ'(0));
            if (nd == NSZ'(0)) vo <= '0;
            else               vo <= neg ? (DSZ'(0) - mag) : mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
